// File: rtl/mem_request_sequencer_if.sv
// Requester, read-return and memory-side signals of mem_request_sequencer.
// The slave modport is the sequencer's view; master is the requester/memory side.
interface mem_request_sequencer_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 16
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_data_i;
    logic              rd_valid_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              busy_o;
    logic              init_done_o;
    logic              mem_go_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_data_i, mem_data_i,
        output req_ready_o, rd_valid_o, rd_data_o, busy_o, init_done_o,
               mem_go_o, mem_we_o, mem_addr_o, mem_data_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_data_i, mem_data_i,
        input  req_ready_o, rd_valid_o, rd_data_o, busy_o, init_done_o,
               mem_go_o, mem_we_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/mem_request_sequencer.sv
// Request FIFO plus access sequencer in front of memory_interface: waits out RAM power-up,
// then issues queued requests one at a time as timed go pulses and returns read data.
module mem_request_sequencer #(
    parameter int ADDR_W        = 26,
    parameter int DATA_W        = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int INIT_CYCLES   = 20000,
    parameter int GO_CYCLES     = 4,
    parameter int ACCESS_CYCLES = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    mem_request_sequencer_if.slave bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam int T_MAX0  = (INIT_CYCLES > GO_CYCLES) ? INIT_CYCLES : GO_CYCLES;
    localparam int T_MAX   = (T_MAX0 > ACCESS_CYCLES) ? T_MAX0 : ACCESS_CYCLES;
    localparam int TMR_W   = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_GO,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               ready_en;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    logic [ENTRY_W-1:0] head;
    logic               head_we;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;

    logic               go;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_data;
    logic               rd_valid;
    logic [DATA_W-1:0]  rd_data;
    logic               init_done;

    // ready_en keeps req_ready_o low until the first edge after reset release
    assign full            = (count == CNT_W'(FIFO_DEPTH));
    assign empty           = (count == '0);
    assign bus.req_ready_o = ready_en & ~full;
    assign push            = bus.req_valid_i & bus.req_ready_o;
    assign pop             = (state == S_IDLE) & ~empty;

    assign head      = fifo_mem[rd_ptr];
    assign head_we   = head[ENTRY_W-1];
    assign head_addr = head[DATA_W +: ADDR_W];
    assign head_data = head[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.req_we_i, bus.req_addr_i, bus.req_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Access sequencer; the memory-side fields stay latched until the next issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            timer     <= '0;
            go        <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (timer == TMR_W'(INIT_CYCLES - 1)) begin
                        init_done <= 1'b1;
                        timer     <= '0;
                        state     <= S_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_IDLE: begin
                    if (pop) begin
                        mem_we   <= head_we;
                        mem_addr <= head_addr;
                        mem_data <= head_data;
                        go       <= 1'b1;
                        timer    <= '0;
                        state    <= S_GO;
                    end
                end
                S_GO: begin
                    if (timer == TMR_W'(GO_CYCLES - 1)) begin
                        go    <= 1'b0;
                        timer <= '0;
                        state <= S_WAIT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_WAIT: begin
                    if (timer == TMR_W'(ACCESS_CYCLES - 1)) begin
                        if (!mem_we) begin
                            rd_data  <= bus.mem_data_i;
                            rd_valid <= 1'b1;
                        end
                        timer <= '0;
                        state <= S_DONE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_DONE: begin
                    rd_valid <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    assign bus.mem_go_o    = go;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_data_o  = mem_data;
    assign bus.rd_valid_o  = rd_valid;
    assign bus.rd_data_o   = rd_data;
    assign bus.init_done_o = init_done;
    assign bus.busy_o      = ~empty | ((state != S_IDLE) && (state != S_INIT));

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Randomized bench for mem_request_sequencer with a memory responder and an in-order
// reference model of issued requests, timing and read data.
module tb_mem_request_sequencer;
    localparam int ADDR_W        = 26;
    localparam int DATA_W        = 16;
    localparam int FIFO_DEPTH    = 4;
    localparam int INIT_CYCLES   = 100;
    localparam int GO_CYCLES     = 4;
    localparam int ACCESS_CYCLES = 16;
    localparam int SPACING       = 1 + GO_CYCLES + ACCESS_CYCLES + 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef struct { bit we; addr_t addr; data_t data; } req_t;
    typedef struct { bit we; addr_t addr; data_t data; int rise; } iss_t;
    typedef struct { data_t data; int at; } rd_t;

    logic  clk    = 1'b0;
    logic  rst_n  = 1'b0;
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;

    iss_t  issued[$];
    int    falls[$];
    rd_t   reads[$];
    req_t  accepted[$];
    int    unstable = 0;
    int    rd_long  = 0;
    int    window   = 0;
    bit    go_prev  = 1'b0;
    bit    rdv_prev = 1'b0;
    req_t  cur;
    data_t mem_store [addr_t];
    data_t ref_mem [addr_t];

    mem_request_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_request_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
        .INIT_CYCLES(INIT_CYCLES), .GO_CYCLES(GO_CYCLES), .ACCESS_CYCLES(ACCESS_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic data_t dflt(input addr_t a);
        return a[DATA_W-1:0] ^ 16'h5A3C;
    endfunction

    function automatic data_t mem_read(input addr_t a);
        return mem_store.exists(a) ? mem_store[a] : dflt(a);
    endfunction

    function automatic data_t ref_read(input addr_t a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Memory responder and bus monitor, both working on the falling edge
    always @(negedge clk) begin
        if (bus.mem_go_o && !go_prev) begin
            issued.push_back('{bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, cyc});
            cur    = '{bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o};
            window = GO_CYCLES + ACCESS_CYCLES - 1;
            if (bus.mem_we_o) mem_store[bus.mem_addr_o] = bus.mem_data_o;
        end else if (window > 0) begin
            window--;
            if (bus.mem_we_o !== cur.we || bus.mem_addr_o !== cur.addr || bus.mem_data_o !== cur.data)
                unstable++;
        end
        if (!bus.mem_go_o && go_prev) falls.push_back(cyc);
        if (bus.rd_valid_o) begin
            if (rdv_prev) rd_long++;
            else reads.push_back('{bus.rd_data_o, cyc});
        end
        go_prev        = bus.mem_go_o;
        rdv_prev       = bus.rd_valid_o;
        bus.mem_data_i = mem_read(bus.mem_addr_o);
    end

    task automatic clear_queues();
        issued.delete();
        falls.delete();
        reads.delete();
        accepted.delete();
    endtask

    task automatic push_req(input bit we, input addr_t addr, input data_t data, input int max_wait,
                            output bit ok, output int waited, output int seen_at);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_data_i  = data;
        waited = 0;
        while (!bus.req_ready_o && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        ok      = bus.req_ready_o;
        seen_at = cyc;
        if (ok) begin
            accepted.push_back('{we, addr, data});
            @(negedge clk);
        end
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_init(output int done_at, output bit ok);
        int n = 0;
        while (!bus.init_done_o && n < INIT_CYCLES + 10) begin
            @(negedge clk);
            n++;
        end
        ok      = bus.init_done_o;
        done_at = cyc;
    endtask

    task automatic wait_idle(output int at, output bit ok);
        int n = 0;
        while (bus.busy_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ok = !bus.busy_o;
        at = cyc;
    endtask

    task automatic test_reset();
        int rel, done_at, t, w, s;
        bit ok;
        addr_t a;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus.req_ready_o); end
        checks++; if (bus.mem_go_o !== 1'b0) begin errors++; $display("FAIL rst_go: got %b want 0", bus.mem_go_o); end
        checks++; if (bus.init_done_o !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b want 0", bus.init_done_o); end
        checks++; if (bus.rd_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_rdv_busy: got %b%b want 00", bus.rd_valid_o, bus.busy_o); end
        checks++; if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, bus.rd_data_o} !== '0) begin
            errors++; $display("FAIL rst_data: got %h/%h/%h/%h want 0", bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, bus.rd_data_o); end
        rst_n = 1'b1;
        rel   = cyc;
        checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL rel_ready_early: got %b want 0", bus.req_ready_o); end
        @(negedge clk);
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", bus.req_ready_o); end
        clear_queues();
        a = addr_t'($urandom_range(100, 200));
        push_req(1'b0, a, '0, 5, ok, w, s);
        checks++; if (!ok) begin errors++; $display("FAIL init_push: got not accepted want accepted"); end
        wait_init(done_at, ok);
        checks++; if (!ok || done_at - rel != INIT_CYCLES) begin
            errors++; $display("FAIL init_time: got %0d want %0d", done_at - rel, INIT_CYCLES); end
        checks++; if (issued.size() != 0) begin errors++; $display("FAIL go_before_init: got %0d issues want 0", issued.size()); end
        wait_idle(t, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t1_idle_timeout: busy still %b want 0", bus.busy_o); end
        checks++; if (issued.size() != 1 || issued[0].rise != done_at + 1 || issued[0].addr !== a) begin
            errors++; $display("FAIL first_issue: got n=%0d rise=%0d want n=1 rise=%0d", issued.size(), issued.size() > 0 ? issued[0].rise : -1, done_at + 1); end
        checks++; if (reads.size() != 1 || reads[0].data !== ref_read(a)) begin
            errors++; $display("FAIL t1_read: got n=%0d want n=1 data %h", reads.size(), ref_read(a)); end
    endtask

    task automatic test_read();
        int t, w, s;
        bit ok;
        clear_queues();
        mem_store[26'd31] = 16'h1234;
        ref_mem[26'd31]   = 16'h1234;
        push_req(1'b0, 26'd31, '0, 5, ok, w, s);
        wait_idle(t, ok);
        checks++; if (!ok || issued.size() != 1 || falls.size() != 1) begin
            errors++; $display("FAIL t2_issue: got issues=%0d falls=%0d want 1/1", issued.size(), falls.size()); end
        else begin
            checks++; if (issued[0].addr !== 26'd31 || issued[0].we !== 1'b0) begin
                errors++; $display("FAIL t2_addr_we: got %0d/%b want 31/0", issued[0].addr, issued[0].we); end
            checks++; if (falls[0] - issued[0].rise != GO_CYCLES) begin
                errors++; $display("FAIL t2_go_len: got %0d want %0d", falls[0] - issued[0].rise, GO_CYCLES); end
            checks++; if (reads.size() != 1 || reads[0].at - falls[0] != ACCESS_CYCLES || reads[0].data !== 16'h1234) begin
                errors++; $display("FAIL t2_rd: got n=%0d data %h want n=1 data 1234 at +%0d", reads.size(), bus.rd_data_o, ACCESS_CYCLES); end
        end
        checks++; if (rd_long != 0 || bus.rd_data_o !== 16'h1234) begin
            errors++; $display("FAIL t2_rd_hold: got long=%0d data %h want 0/1234", rd_long, bus.rd_data_o); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL t2_stable: got %0d changes want 0", unstable); end
    endtask

    task automatic test_write();
        int t, w, s;
        bit ok;
        clear_queues();
        push_req(1'b1, 26'd20, 16'hBEEF, 5, ok, w, s);
        ref_mem[26'd20] = 16'hBEEF;
        wait_idle(t, ok);
        checks++; if (!ok || issued.size() != 1 || issued[0].we !== 1'b1 || issued[0].addr !== 26'd20 || issued[0].data !== 16'hBEEF) begin
            errors++; $display("FAIL t3_issue: got n=%0d %b/%0d/%h want 1/20/beef", issued.size(), bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o); end
        checks++; if (reads.size() != 0 || bus.rd_data_o !== 16'h1234) begin
            errors++; $display("FAIL t3_no_rd: got n=%0d data %h want 0/1234", reads.size(), bus.rd_data_o); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL t3_stable: got %0d changes want 0", unstable); end
        clear_queues();
        push_req(1'b0, 26'd20, '0, 5, ok, w, s);
        wait_idle(t, ok);
        checks++; if (reads.size() != 1 || bus.rd_data_o !== 16'hBEEF) begin
            errors++; $display("FAIL t3_readback: got n=%0d data %h want 1/beef", reads.size(), bus.rd_data_o); end
    endtask

    task automatic test_fifo_full();
        int t, w, s, j, rel;
        bit ok;
        bit oks [5];
        data_t e;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        @(negedge clk);
        clear_queues();
        for (int i = 0; i < 5; i++) push_req(1'b0, addr_t'(i + 1), '0, 3, oks[i], w, s);
        checks++; if (oks[0] !== 1'b1 || oks[1] !== 1'b1 || oks[2] !== 1'b1 || oks[3] !== 1'b1 || oks[4] !== 1'b0) begin
            errors++; $display("FAIL t4_accept: got %b%b%b%b%b want 11110", oks[0], oks[1], oks[2], oks[3], oks[4]); end
        checks++; if (bus.req_ready_o !== 1'b0 || bus.init_done_o !== 1'b0) begin
            errors++; $display("FAIL t4_full_ready: got ready=%b init=%b want 0/0", bus.req_ready_o, bus.init_done_o); end
        wait_idle(t, ok);
        checks++; if (!ok || issued.size() != 4) begin errors++; $display("FAIL t4_count: got %0d want 4", issued.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (issued[i].addr !== addr_t'(i + 1)) begin
                    errors++; $display("FAIL t4_order[%0d]: got %0d want %0d", i, issued[i].addr, i + 1); end
                if (i > 0) begin
                    checks++; if (issued[i].rise - issued[i-1].rise != SPACING) begin
                        errors++; $display("FAIL t4_spacing[%0d]: got %0d want %0d", i, issued[i].rise - issued[i-1].rise, SPACING); end
                end
            end
            checks++; if (issued[0].rise != rel + INIT_CYCLES + 1) begin
                errors++; $display("FAIL t4_first_rise: got %0d want %0d", issued[0].rise - rel, INIT_CYCLES + 1); end
            checks++; if (t != issued[3].rise + SPACING - 1) begin
                errors++; $display("FAIL t4_busy_drop: got %0d want %0d", t - issued[3].rise, SPACING - 1); end
        end
        j = 0;
        foreach (accepted[i]) begin
            e = ref_read(accepted[i].addr);
            checks++; if (j >= reads.size() || reads[j].data !== e) begin
                errors++; $display("FAIL t4_rdata[%0d]: got %h want %h", j, j < reads.size() ? reads[j].data : data_t'('x), e); end
            j++;
        end
    endtask

    task automatic test_push_pop_full();
        int t, w, s, j, n;
        bit ok, found;
        int blocked[$];
        data_t e;
        clear_queues();
        for (int i = 0; i < 12; i++) begin
            push_req(1'($urandom_range(0, 1)), addr_t'($urandom_range(0, 63)), data_t'($urandom), 100, ok, w, s);
            checks++; if (!ok) begin errors++; $display("FAIL t5_push[%0d]: got not accepted want accepted", i); end
            if (w > 0) blocked.push_back(s);
        end
        wait_idle(t, ok);
        checks++; if (!ok || blocked.size() == 0) begin
            errors++; $display("FAIL t5_blocked: got idle=%b blocked=%0d want 1/>0", ok, blocked.size()); end
        foreach (blocked[b]) begin
            found = 1'b0;
            foreach (issued[k]) if (issued[k].rise == blocked[b]) found = 1'b1;
            checks++; if (!found) begin errors++; $display("FAIL t5_ready_reassert: got ready at %0d want at a pop cycle", blocked[b]); end
        end
        checks++; if (issued.size() != accepted.size()) begin
            errors++; $display("FAIL t5_count: got %0d want %0d", issued.size(), accepted.size()); end
        n = (issued.size() < accepted.size()) ? issued.size() : accepted.size();
        j = 0;
        for (int i = 0; i < n; i++) begin
            checks++; if (issued[i].we !== accepted[i].we || issued[i].addr !== accepted[i].addr ||
                          (accepted[i].we && issued[i].data !== accepted[i].data)) begin
                errors++; $display("FAIL t5_issue[%0d]: got %b/%0h/%h want %b/%0h/%h", i, issued[i].we, issued[i].addr,
                                   issued[i].data, accepted[i].we, accepted[i].addr, accepted[i].data); end
            if (i > 0) begin
                checks++; if (issued[i].rise - issued[i-1].rise != SPACING) begin
                    errors++; $display("FAIL t5_spacing[%0d]: got %0d want %0d", i, issued[i].rise - issued[i-1].rise, SPACING); end
            end
            if (accepted[i].we) ref_mem[accepted[i].addr] = accepted[i].data;
            else begin
                e = ref_read(accepted[i].addr);
                checks++; if (j >= reads.size() || reads[j].data !== e) begin
                    errors++; $display("FAIL t5_rdata[%0d]: got %h want %h", i, j < reads.size() ? reads[j].data : data_t'('x), e); end
                j++;
            end
        end
        checks++; if (reads.size() != j || rd_long != 0 || unstable != 0) begin
            errors++; $display("FAIL t5_reads: got n=%0d long=%0d unstable=%0d want %0d/0/0", reads.size(), rd_long, unstable, j); end
    endtask

    task automatic test_reset_mid_wait();
        int w, s, n, rel, done_at;
        bit ok;
        clear_queues();
        push_req(1'b0, 26'd40, '0, 5, ok, w, s);
        push_req(1'b0, 26'd41, '0, 5, ok, w, s);
        push_req(1'b0, 26'd42, '0, 5, ok, w, s);
        n = 0;
        while (falls.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++; if (falls.size() == 0) begin errors++; $display("FAIL t6_go_fall: got no go fall want one"); end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_go_o !== 1'b0 || bus.rd_valid_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
            errors++; $display("FAIL t6_rst_out: got go=%b rdv=%b rdy=%b want 000", bus.mem_go_o, bus.rd_valid_o, bus.req_ready_o); end
        checks++; if (bus.busy_o !== 1'b0 || bus.init_done_o !== 1'b0) begin
            errors++; $display("FAIL t6_rst_state: got busy=%b init=%b want 00", bus.busy_o, bus.init_done_o); end
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        wait_init(done_at, ok);
        checks++; if (!ok || done_at - rel != INIT_CYCLES) begin
            errors++; $display("FAIL t6_init_time: got %0d want %0d", done_at - rel, INIT_CYCLES); end
        repeat (40) @(negedge clk);
        checks++; if (issued.size() != 1 || reads.size() != 0 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL t6_abandon: got issues=%0d reads=%0d busy=%b want 1/0/0", issued.size(), reads.size(), bus.busy_o); end
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;
        test_reset();
        test_read();
        test_write();
        test_fifo_full();
        test_push_pop_full();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
